// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage.
//   LoadType_t   : {ReadMem, Sign, Size[1:0], LR} describing a load in flight
//   RegsWrType_t : {RFWr, HIWr, LOWr} architectural write enables
//   WBSEL_*      : GPR write-value source select
//   SIZE_*       : load access size; SIZE_LWLR marks LWL/LWR, with LR choosing which
package wb_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_LWLR = 2'b11;

    localparam logic [1:0] WBSEL_ALUOUT = 2'b00;
    localparam logic [1:0] WBSEL_OUTB   = 2'b01;
    localparam logic [1:0] WBSEL_DMOUT  = 2'b10;

    typedef struct packed {
        logic       ReadMem;
        logic       Sign;
        logic [1:0] Size;
        logic       LR;
    } LoadType_t;

    typedef struct packed {
        logic RFWr;
        logic HIWr;
        logic LOWr;
    } RegsWrType_t;

    typedef enum logic {
        HOLD_IDLE = 1'b0,
        HOLD_HELD = 1'b1
    } hold_state_t;

endpackage

// File: rtl/wb_stage_load.sv
// load_align: combinational alignment and extension of DCache read data.
// Ports:
//   dm_i    raw 32-bit load data (little-endian word)
//   rt_i    rt register value, merge source for LWL/LWR
//   addr_i  effective address bits [1:0]
//   sign_i  sign-extend byte/half results
//   size_i  access size (SIZE_*)
//   lr_i    0 = LWL, 1 = LWR (only meaningful with SIZE_LWLR)
//   data_o  aligned 32-bit result
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] dm_i,
    input  logic [31:0] rt_i,
    input  logic [1:0]  addr_i,
    input  logic        sign_i,
    input  logic [1:0]  size_i,
    input  logic        lr_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm_i[7:0];
        case (addr_i)
            2'd1:    byte_sel = dm_i[15:8];
            2'd2:    byte_sel = dm_i[23:16];
            2'd3:    byte_sel = dm_i[31:24];
            default: byte_sel = dm_i[7:0];
        endcase

        half_sel = addr_i[1] ? dm_i[31:16] : dm_i[15:0];

        data_o = dm_i;
        case (size_i)
            SIZE_BYTE: data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            SIZE_WORD: data_o = dm_i;
            default: begin
                if (!lr_i) begin
                    // LWL: memory bytes fill the register from the top down
                    case (addr_i)
                        2'd0:    data_o = {dm_i[7:0],  rt_i[23:0]};
                        2'd1:    data_o = {dm_i[15:0], rt_i[15:0]};
                        2'd2:    data_o = {dm_i[23:0], rt_i[7:0]};
                        default: data_o = dm_i;
                    endcase
                end else begin
                    // LWR: memory bytes fill the register from the bottom up
                    case (addr_i)
                        2'd0:    data_o = dm_i;
                        2'd1:    data_o = {rt_i[31:24], dm_i[31:8]};
                        2'd2:    data_o = {rt_i[31:16], dm_i[31:16]};
                        default: data_o = {rt_i[31:8],  dm_i[31:24]};
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load alignment, GPR write select,
// HI/LO commit, WB bypass/delay-slot exports and debug trace.
// A one-entry hold buffer captures DCache data that arrives while the stage
// is stalled, so the data is still available when the stage finally advances.
//
// State | meaning
// IDLE  | load data (if any) comes straight from DM_RData
// HELD  | load data was captured in hold_q; DM_RData/DM_RValid ignored
//
// Ports: clk/rst; WB_Flush, WB_Wr stage control; MEM_* incoming instruction;
// DM_RData/DM_RValid DCache return; WB_* GPR write, bypass and flag outputs;
// HI/LO architectural registers; debug_wb_* retire trace.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter bit          DEBUG_EN = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_Flush,
    input  logic        WB_Wr,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_OutB,
    input  logic [31:0] MEM_PC,
    input  logic [4:0]  MEM_Dst,
    input  logic [4:0]  MEM_LoadType,
    input  logic [1:0]  MEM_WbSel,
    input  logic [2:0]  MEM_RegsWrType,
    input  logic [31:0] MEM_Hi,
    input  logic [31:0] MEM_Lo,
    input  logic        MEM_IsABranch,
    input  logic        MEM_IsAImmeJump,
    input  logic [31:0] DM_RData,
    input  logic        DM_RValid,
    output logic        WB_RF_We,
    output logic [4:0]  WB_RF_Dst,
    output logic [31:0] WB_Result,
    output logic [4:0]  WB_Dst,
    output logic [2:0]  WB_RegsWrType,
    output logic        WB_LoadPending,
    output logic        WB_IsABranch,
    output logic        WB_IsAImmeJump,
    output logic [31:0] WB_PC,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic [31:0] alu_q, outb_q, pc_q, hi_in_q, lo_in_q;
    logic [4:0]  dst_q;
    logic [1:0]  wbsel_q;
    LoadType_t   lt_q;
    RegsWrType_t rwt_q;
    logic        br_q, jmp_q;

    hold_state_t state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] dm, load_data;
    logic        commit;

    // MEM/WB pipeline register; flush wins over advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q   <= '0;
            outb_q  <= '0;
            pc_q    <= RESET_PC;
            hi_in_q <= '0;
            lo_in_q <= '0;
            dst_q   <= '0;
            wbsel_q <= '0;
            lt_q    <= '0;
            rwt_q   <= '0;
            br_q    <= 1'b0;
            jmp_q   <= 1'b0;
        end else if (WB_Flush) begin
            alu_q   <= '0;
            outb_q  <= '0;
            pc_q    <= RESET_PC;
            hi_in_q <= '0;
            lo_in_q <= '0;
            dst_q   <= '0;
            wbsel_q <= '0;
            lt_q    <= '0;
            rwt_q   <= '0;
            br_q    <= 1'b0;
            jmp_q   <= 1'b0;
        end else if (WB_Wr) begin
            alu_q   <= MEM_ALUOut;
            outb_q  <= MEM_OutB;
            pc_q    <= MEM_PC;
            hi_in_q <= MEM_Hi;
            lo_in_q <= MEM_Lo;
            dst_q   <= MEM_Dst;
            wbsel_q <= MEM_WbSel;
            lt_q    <= LoadType_t'(MEM_LoadType);
            rwt_q   <= RegsWrType_t'(MEM_RegsWrType);
            br_q    <= MEM_IsABranch;
            jmp_q   <= MEM_IsAImmeJump;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD_IDLE;
            hold_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            HOLD_IDLE: begin
                // data arrived but the stage cannot advance: keep it
                if (lt_q.ReadMem && DM_RValid && !WB_Wr && !WB_Flush) begin
                    state_d = HOLD_HELD;
                    hold_d  = DM_RData;
                end
            end
            HOLD_HELD: begin
                if (WB_Wr || WB_Flush) begin
                    state_d = HOLD_IDLE;
                    hold_d  = '0;
                end
            end
            default: state_d = HOLD_IDLE;
        endcase
    end

    assign dm             = (state_q == HOLD_HELD) ? hold_q : DM_RData;
    assign WB_LoadPending = lt_q.ReadMem & (state_q != HOLD_HELD) & ~DM_RValid;
    // the only cycle an instruction writes architectural state is when it leaves WB
    assign commit         = WB_Wr & ~WB_LoadPending;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (rwt_q.HIWr && commit) hi_d = hi_in_q;
        if (rwt_q.LOWr && commit) lo_d = lo_in_q;
    end

    load_align u_load_align (
        .dm_i   (dm),
        .rt_i   (outb_q),
        .addr_i (alu_q[1:0]),
        .sign_i (lt_q.Sign),
        .size_i (lt_q.Size),
        .lr_i   (lt_q.LR),
        .data_o (load_data)
    );

    always_comb begin
        case (wbsel_q)
            WBSEL_OUTB:  WB_Result = outb_q;
            WBSEL_DMOUT: WB_Result = load_data;
            default:     WB_Result = alu_q;
        endcase
    end

    assign WB_RF_We       = rwt_q.RFWr & commit;
    assign WB_RF_Dst      = dst_q;
    assign WB_Dst         = dst_q;
    assign WB_RegsWrType  = rwt_q;
    assign WB_IsABranch   = br_q;
    assign WB_IsAImmeJump = jmp_q;
    assign WB_PC          = pc_q;
    assign HI             = hi_q;
    assign LO             = lo_q;

    generate
        if (DEBUG_EN) begin : g_debug
            assign debug_wb_pc       = pc_q;
            assign debug_wb_rf_wen   = {4{WB_RF_We}};
            assign debug_wb_rf_wnum  = dst_q;
            assign debug_wb_rf_wdata = WB_Result;
        end else begin : g_no_debug
            assign debug_wb_pc       = '0;
            assign debug_wb_rf_wen   = '0;
            assign debug_wb_rf_wnum  = '0;
            assign debug_wb_rf_wdata = '0;
        end
    endgenerate

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_Flush, WB_Wr;
    logic [31:0] MEM_ALUOut, MEM_OutB, MEM_PC, MEM_Hi, MEM_Lo;
    logic [4:0]  MEM_Dst, MEM_LoadType;
    logic [1:0]  MEM_WbSel;
    logic [2:0]  MEM_RegsWrType;
    logic        MEM_IsABranch, MEM_IsAImmeJump;
    logic [31:0] DM_RData;
    logic        DM_RValid;
    logic        WB_RF_We;
    logic [4:0]  WB_RF_Dst, WB_Dst;
    logic [31:0] WB_Result, WB_PC, HI, LO;
    logic [2:0]  WB_RegsWrType;
    logic        WB_LoadPending, WB_IsABranch, WB_IsAImmeJump;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    always #5 clk = ~clk;

    wb_stage #(.DEBUG_EN(1'b1), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .WB_Flush(WB_Flush), .WB_Wr(WB_Wr),
        .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB), .MEM_PC(MEM_PC), .MEM_Dst(MEM_Dst),
        .MEM_LoadType(MEM_LoadType), .MEM_WbSel(MEM_WbSel), .MEM_RegsWrType(MEM_RegsWrType),
        .MEM_Hi(MEM_Hi), .MEM_Lo(MEM_Lo), .MEM_IsABranch(MEM_IsABranch),
        .MEM_IsAImmeJump(MEM_IsAImmeJump), .DM_RData(DM_RData), .DM_RValid(DM_RValid),
        .WB_RF_We(WB_RF_We), .WB_RF_Dst(WB_RF_Dst), .WB_Result(WB_Result), .WB_Dst(WB_Dst),
        .WB_RegsWrType(WB_RegsWrType), .WB_LoadPending(WB_LoadPending),
        .WB_IsABranch(WB_IsABranch), .WB_IsAImmeJump(WB_IsAImmeJump), .WB_PC(WB_PC),
        .HI(HI), .LO(LO), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // Reference load result, from byte-lane arithmetic on the architectural rules
    function automatic logic [31:0] exp_load(input logic [31:0] dm, input logic [31:0] rt,
                                             input int a, input logic sgn,
                                             input logic [1:0] size, input logic lr);
        logic [31:0] v;
        logic [31:0] keep;
        case (size)
            2'd0: begin
                v = (dm >> (8 * a)) & 32'h0000_00FF;
                if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (dm >> (16 * (a / 2))) & 32'h0000_FFFF;
                if (sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            2'd2: v = dm;
            default: begin
                if (!lr) begin
                    keep = (a == 3) ? 32'h0 : (32'hFFFF_FFFF >> (8 * (a + 1)));
                    v = (dm << (8 * (3 - a))) | (rt & keep);
                end else begin
                    keep = ~(32'hFFFF_FFFF >> (8 * a));
                    v = (dm >> (8 * a)) | (rt & keep);
                end
            end
        endcase
        return v;
    endfunction

    task automatic mem_drive(input logic [4:0] lt, input logic [1:0] ws, input logic [2:0] rwt,
                             input logic [31:0] alu, input logic [31:0] outb, input logic [31:0] pc,
                             input logic [4:0] dst, input logic [31:0] hi, input logic [31:0] lo,
                             input logic br, input logic jmp);
        MEM_LoadType = lt; MEM_WbSel = ws; MEM_RegsWrType = rwt;
        MEM_ALUOut = alu; MEM_OutB = outb; MEM_PC = pc; MEM_Dst = dst;
        MEM_Hi = hi; MEM_Lo = lo; MEM_IsABranch = br; MEM_IsAImmeJump = jmp;
    endtask

    task automatic mem_bubble();
        mem_drive(5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; WB_Flush = 1'b0; WB_Wr = 1'b0; DM_RData = 32'h0; DM_RValid = 1'b0;
        mem_bubble();
        @(negedge clk); #1;
        checks++; if (WB_PC !== RPC) begin errors++; $display("FAIL reset_pc got %h exp %h", WB_PC, RPC); end
        checks++; if (debug_wb_pc !== RPC) begin errors++; $display("FAIL reset_dbg_pc got %h exp %h", debug_wb_pc, RPC); end
        checks++; if (WB_Result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", WB_Result); end
        checks++; if ({WB_RF_We, WB_LoadPending, WB_IsABranch, WB_IsAImmeJump} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b exp 0000", {WB_RF_We, WB_LoadPending, WB_IsABranch, WB_IsAImmeJump}); end
        checks++; if ({WB_Dst, WB_RF_Dst, WB_RegsWrType} !== 13'h0) begin errors++;
            $display("FAIL reset_dst got %h exp 0", {WB_Dst, WB_RF_Dst, WB_RegsWrType}); end
        checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h exp 0", {HI, LO}); end
        checks++; if ({debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== 41'h0) begin errors++;
            $display("FAIL reset_debug got %h exp 0", {debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata}); end
        rst = 1'b0;
    endtask

    task automatic test_lb_signed();
        @(negedge clk);
        mem_drive(5'b1_1_00_0, 2'b10, 3'b100, 32'h1000_0002, 32'h0, 32'h0040_0010, 5'd3,
                  32'h0, 32'h0, 1'b0, 1'b0);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        @(negedge clk);
        mem_bubble(); DM_RData = 32'h1280_3456; DM_RValid = 1'b1; WB_Wr = 1'b1;
        #1;
        checks++; if (WB_Result !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_result got %h exp ffffff80", WB_Result); end
        checks++; if (WB_RF_We !== 1'b1) begin errors++; $display("FAIL lb_we got %b exp 1", WB_RF_We); end
        checks++; if (WB_RF_Dst !== 5'd3) begin errors++; $display("FAIL lb_dst got %0d exp 3", WB_RF_Dst); end
        @(negedge clk); DM_RValid = 1'b0; #1;
        checks++; if (WB_RF_We !== 1'b0) begin errors++; $display("FAIL lb_single_we got %b exp 0", WB_RF_We); end
    endtask

    task automatic test_lwl_lwr();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_drive((k == 0) ? 5'b1_0_11_0 : 5'b1_0_11_1, 2'b10, 3'b100,
                      (k == 0) ? 32'h2000_0001 : 32'h2000_0002, 32'hAABB_CCDD,
                      32'h0040_0020, 5'd4, 32'h0, 32'h0, 1'b0, 1'b0);
            WB_Wr = 1'b1; DM_RValid = 1'b0;
            @(negedge clk);
            mem_bubble(); DM_RData = 32'h1122_3344; DM_RValid = 1'b1; WB_Wr = 1'b1;
            #1;
            checks++;
            if (WB_Result !== ((k == 0) ? 32'h3344_CCDD : 32'hAABB_1122)) begin errors++;
                $display("FAIL lwlr_%0d got %h exp %h", k, WB_Result, (k == 0) ? 32'h3344_CCDD : 32'hAABB_1122); end
        end
        @(negedge clk); DM_RValid = 1'b0;
    endtask

    task automatic test_stall();
        @(negedge clk);
        mem_drive(5'b1_0_10_0, 2'b10, 3'b100, 32'h3000_0000, 32'h0, 32'h0040_0030, 5'd5,
                  32'h0, 32'h0, 1'b0, 1'b0);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_bubble(); WB_Wr = 1'b0; DM_RValid = 1'b1; DM_RData = 32'h0BAD_F00D;
            #1;
            checks++; if (WB_RF_We !== 1'b0) begin errors++; $display("FAIL stall_we_%0d got %b exp 0", c, WB_RF_We); end
            checks++; if (WB_Result !== 32'h0BAD_F00D) begin errors++; $display("FAIL stall_res_%0d got %h exp 0badf00d", c, WB_Result); end
        end
        @(negedge clk);
        WB_Wr = 1'b0; DM_RValid = 1'b1; DM_RData = 32'h1234_5678;
        #1;
        checks++; if (WB_Result !== 32'h0BAD_F00D) begin errors++; $display("FAIL stall_held got %h exp 0badf00d", WB_Result); end
        @(negedge clk);
        WB_Wr = 1'b1; DM_RValid = 1'b0; DM_RData = 32'h8765_4321;
        #1;
        checks++; if (WB_RF_We !== 1'b1) begin errors++; $display("FAIL stall_commit got %b exp 1", WB_RF_We); end
        checks++; if (WB_Result !== 32'h0BAD_F00D) begin errors++; $display("FAIL stall_commit_res got %h exp 0badf00d", WB_Result); end
        @(negedge clk); #1;
        checks++; if (WB_RF_We !== 1'b0) begin errors++; $display("FAIL stall_once got %b exp 0", WB_RF_We); end
    endtask

    task automatic test_miss();
        @(negedge clk);
        mem_drive(5'b1_0_10_0, 2'b10, 3'b110, 32'h4000_0000, 32'h0, 32'h0040_0040, 5'd9,
                  32'hDEAD_0001, 32'h0, 1'b0, 1'b0);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            WB_Wr = 1'b1; DM_RValid = 1'b0;   // same load re-presented on MEM
            #1;
            checks++; if (WB_LoadPending !== 1'b1) begin errors++; $display("FAIL miss_pend_%0d got %b exp 1", c, WB_LoadPending); end
            checks++; if (WB_RF_We !== 1'b0) begin errors++; $display("FAIL miss_we_%0d got %b exp 0", c, WB_RF_We); end
            checks++; if (HI !== exp_hi) begin errors++; $display("FAIL miss_hi_%0d got %h exp %h", c, HI, exp_hi); end
        end
        @(negedge clk);
        mem_bubble(); WB_Wr = 1'b1; DM_RValid = 1'b1; DM_RData = 32'h5A5A_1234;
        #1;
        checks++; if (WB_RF_We !== 1'b1) begin errors++; $display("FAIL miss_arrive_we got %b exp 1", WB_RF_We); end
        checks++; if (WB_Result !== 32'h5A5A_1234) begin errors++; $display("FAIL miss_arrive_res got %h exp 5a5a1234", WB_Result); end
        exp_hi = 32'hDEAD_0001;
        @(negedge clk); DM_RValid = 1'b0; #1;
        checks++; if (WB_RF_We !== 1'b0) begin errors++; $display("FAIL miss_once got %b exp 0", WB_RF_We); end
        checks++; if (HI !== exp_hi) begin errors++; $display("FAIL miss_hi_commit got %h exp %h", HI, exp_hi); end
    endtask

    task automatic test_hilo();
        @(negedge clk);
        mem_drive(5'd0, 2'b00, 3'b011, 32'h0, 32'h0, 32'h0040_0050, 5'd0, 32'd5, 32'd7, 1'b0, 1'b0);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        @(negedge clk);
        mem_bubble(); WB_Wr = 1'b1;
        @(negedge clk); #1;
        exp_hi = 32'd5; exp_lo = 32'd7;
        checks++; if (HI !== exp_hi) begin errors++; $display("FAIL hilo_hi got %h exp %h", HI, exp_hi); end
        checks++; if (LO !== exp_lo) begin errors++; $display("FAIL hilo_lo got %h exp %h", LO, exp_lo); end
        mem_drive(5'd0, 2'b00, 3'b011, 32'h0, 32'h0, 32'h0040_0060, 5'd0, 32'd9, 32'd11, 1'b1, 1'b1);
        WB_Flush = 1'b1; WB_Wr = 1'b1;
        @(negedge clk);
        WB_Flush = 1'b0; mem_bubble(); WB_Wr = 1'b1;
        #1;
        checks++; if (WB_PC !== RPC) begin errors++; $display("FAIL flush_pc got %h exp %h", WB_PC, RPC); end
        checks++; if ({WB_RegsWrType, WB_IsABranch, WB_IsAImmeJump} !== 5'b0) begin errors++;
            $display("FAIL flush_bubble got %b exp 0", {WB_RegsWrType, WB_IsABranch, WB_IsAImmeJump}); end
        @(negedge clk); #1;
        checks++; if ({HI, LO} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL flush_hilo got %h exp %h", {HI, LO}, {exp_hi, exp_lo}); end
    endtask

    task automatic test_flush_midload();
        @(negedge clk);
        mem_drive(5'b1_0_10_0, 2'b10, 3'b100, 32'h5000_0000, 32'h0, 32'h0040_0070, 5'd12,
                  32'h0, 32'h0, 1'b0, 1'b0);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        @(negedge clk);
        mem_bubble(); WB_Wr = 1'b0; DM_RValid = 1'b1; DM_RData = 32'h7777_0000;
        @(negedge clk);
        DM_RValid = 1'b0; WB_Flush = 1'b1; WB_Wr = 1'b0;
        #1;
        checks++; if (WB_RF_We !== 1'b0) begin errors++; $display("FAIL fml_we got %b exp 0", WB_RF_We); end
        @(negedge clk);
        WB_Flush = 1'b0;
        mem_drive(5'b1_0_10_0, 2'b10, 3'b100, 32'h5000_0004, 32'h0, 32'h0040_0074, 5'd13,
                  32'h0, 32'h0, 1'b0, 1'b0);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        #1;
        checks++; if (WB_RF_We !== 1'b0) begin errors++; $display("FAIL fml_nowrite got %b exp 0", WB_RF_We); end
        @(negedge clk);
        mem_bubble(); WB_Wr = 1'b0; DM_RValid = 1'b0;
        #1;
        checks++; if (WB_LoadPending !== 1'b1) begin errors++; $display("FAIL fml_hold_cleared got %b exp 1", WB_LoadPending); end
        @(negedge clk);
        WB_Wr = 1'b1; DM_RValid = 1'b1; DM_RData = 32'h3131_3131;
        #1;
        checks++; if (WB_Result !== 32'h3131_3131) begin errors++; $display("FAIL fml_next_res got %h exp 31313131", WB_Result); end
        @(negedge clk); DM_RValid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] alu, outb, pc, dm, hi, lo, exp_res;
        logic [4:0]  dst;
        logic [1:0]  size, ws;
        logic        sgn, lr, rfwr, hiwr, lowr, br, jmp, isld;
        int          misses, stalls, pick;
        for (int n = 0; n < 60; n++) begin
            isld = 1'($urandom_range(0, 1));
            alu = $urandom; outb = $urandom; pc = $urandom & 32'hFFFF_FFFC; dm = $urandom;
            hi = $urandom; lo = $urandom; dst = 5'($urandom);
            rfwr = 1'($urandom); br = 1'($urandom); jmp = 1'($urandom);
            size = 2'd0; sgn = 1'b0; lr = 1'b0; hiwr = 1'b0; lowr = 1'b0;
            if (isld) begin
                size = 2'($urandom); sgn = 1'($urandom); lr = 1'($urandom); ws = 2'b10;
                exp_res = exp_load(dm, outb, int'(alu[1:0]), sgn, size, lr);
                misses = $urandom_range(0, 2); stalls = $urandom_range(0, 2);
            end else begin
                pick = $urandom_range(0, 2);
                ws = (pick == 2) ? 2'b11 : 2'(pick);
                hiwr = 1'($urandom); lowr = 1'($urandom);
                exp_res = (ws == 2'b01) ? outb : alu;
                misses = 0; stalls = 0;
            end
            @(negedge clk);
            mem_drive({isld, sgn, size, lr}, ws, {rfwr, hiwr, lowr}, alu, outb, pc, dst, hi, lo, br, jmp);
            WB_Wr = 1'b1; WB_Flush = 1'b0; DM_RValid = 1'b0; DM_RData = $urandom;
            #1;
            checks++; if ({HI, LO} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL rnd_hilo_%0d got %h exp %h", n, {HI, LO}, {exp_hi, exp_lo}); end
            for (int m = 0; m < misses; m++) begin
                @(negedge clk);
                mem_bubble(); WB_Wr = 1'b0; DM_RValid = 1'b0; DM_RData = $urandom;
                #1;
                checks++; if ({WB_LoadPending, WB_RF_We} !== 2'b10) begin errors++;
                    $display("FAIL rnd_miss_%0d pend/we got %b exp 10", n, {WB_LoadPending, WB_RF_We}); end
            end
            for (int s = 0; s < stalls; s++) begin
                @(negedge clk);
                mem_bubble(); WB_Wr = 1'b0;
                if (s == 0) begin DM_RValid = 1'b1; DM_RData = dm; end
                else begin DM_RValid = 1'($urandom); DM_RData = $urandom; end
                #1;
                checks++; if (WB_Result !== exp_res) begin errors++; $display("FAIL rnd_stall_%0d got %h exp %h", n, WB_Result, exp_res); end
                checks++; if ({WB_LoadPending, WB_RF_We} !== 2'b00) begin errors++;
                    $display("FAIL rnd_stall_we_%0d got %b exp 00", n, {WB_LoadPending, WB_RF_We}); end
            end
            @(negedge clk);
            mem_bubble(); WB_Wr = 1'b1;
            if (isld && stalls > 0) begin DM_RValid = 1'($urandom); DM_RData = $urandom; end
            else begin DM_RValid = 1'b1; DM_RData = isld ? dm : $urandom; end
            #1;
            checks++; if (WB_Result !== exp_res) begin errors++; $display("FAIL rnd_res_%0d got %h exp %h", n, WB_Result, exp_res); end
            checks++; if (WB_RF_We !== rfwr) begin errors++; $display("FAIL rnd_we_%0d got %b exp %b", n, WB_RF_We, rfwr); end
            checks++; if ({WB_RF_Dst, WB_Dst, WB_RegsWrType} !== {dst, dst, rfwr, hiwr, lowr}) begin errors++;
                $display("FAIL rnd_dst_%0d got %h exp %h", n, {WB_RF_Dst, WB_Dst, WB_RegsWrType}, {dst, dst, rfwr, hiwr, lowr}); end
            checks++; if ({WB_PC, WB_IsABranch, WB_IsAImmeJump} !== {pc, br, jmp}) begin errors++;
                $display("FAIL rnd_pcflags_%0d got %h exp %h", n, {WB_PC, WB_IsABranch, WB_IsAImmeJump}, {pc, br, jmp}); end
            checks++;
            if ({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} !== {pc, {4{rfwr}}, dst, exp_res}) begin errors++;
                $display("FAIL rnd_debug_%0d got %h exp %h", n, {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
                         {pc, {4{rfwr}}, dst, exp_res}); end
            if (hiwr) exp_hi = hi;
            if (lowr) exp_lo = lo;
        end
        @(negedge clk); DM_RValid = 1'b0; #1;
        checks++; if ({HI, LO} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL rnd_hilo_end got %h exp %h", {HI, LO}, {exp_hi, exp_lo}); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        mem_drive(5'b1_0_10_0, 2'b10, 3'b111, 32'h6000_0000, 32'h0, 32'h0040_0080, 5'd17,
                  32'h1, 32'h2, 1'b1, 1'b1);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        @(negedge clk);
        mem_bubble(); WB_Wr = 1'b0; DM_RValid = 1'b1; DM_RData = 32'hCAFE_F00D;
        @(negedge clk);
        DM_RValid = 1'b0; DM_RData = 32'h0;
        #1;
        checks++; if (WB_Result !== 32'hCAFE_F00D) begin errors++; $display("FAIL ar_held got %h exp cafef00d", WB_Result); end
        #1 rst = 1'b1;
        #1;
        exp_hi = 32'h0; exp_lo = 32'h0;
        checks++; if (WB_PC !== RPC) begin errors++; $display("FAIL ar_pc got %h exp %h", WB_PC, RPC); end
        checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL ar_hilo got %h exp 0", {HI, LO}); end
        checks++; if ({WB_Result, WB_RF_We, WB_LoadPending, WB_Dst, WB_RegsWrType, WB_IsABranch, WB_IsAImmeJump} !== 48'h0) begin errors++;
            $display("FAIL ar_outs got %h exp 0", {WB_Result, WB_RF_We, WB_LoadPending, WB_Dst, WB_RegsWrType, WB_IsABranch, WB_IsAImmeJump}); end
        @(negedge clk);
        rst = 1'b0;
        mem_drive(5'b1_0_10_0, 2'b10, 3'b100, 32'h6000_0004, 32'h0, 32'h0040_0084, 5'd18,
                  32'h0, 32'h0, 1'b0, 1'b0);
        WB_Wr = 1'b1; DM_RValid = 1'b0;
        @(negedge clk);
        mem_bubble(); WB_Wr = 1'b0;
        #1;
        checks++; if (WB_LoadPending !== 1'b1) begin errors++; $display("FAIL ar_fsm_idle got %b exp 1", WB_LoadPending); end
        @(negedge clk);
        WB_Wr = 1'b1; DM_RValid = 1'b1; DM_RData = 32'h0000_0042;
        #1;
        checks++; if (WB_Result !== 32'h0000_0042) begin errors++; $display("FAIL ar_after_res got %h exp 42", WB_Result); end
        @(negedge clk); DM_RValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_lwl_lwr();
        test_stall();
        test_miss();
        test_hilo();
        test_flush_midload();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
